// File: rtl/lcd_cmd_seq.sv
// Command sequencer for an LCD controller: queues host command codes in a FIFO and
// issues them one at a time with a busy/done handshake, stopping after the write-out command.
module lcd_cmd_seq #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [3:0] push_cmd,
  output logic       full,
  output logic [4:0] count,
  input  logic       busy,
  input  logic       done,
  output logic [3:0] cmd,
  output logic       cmd_valid,
  output logic       finished,
  output logic       err
);

  // state    | meaning
  // IDLE     | waiting for a queued entry and busy=0
  // ISSUE    | cmd_valid strobe cycle
  // WAIT_ACK | waiting for the controller to raise busy
  // WAIT_REL | controller executing; cmd must stay stable
  // FINISH   | write-out complete, absorbing until reset
  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_ACK, S_WAIT_REL, S_FINISH
  } state_t;

  localparam int         AW      = $clog2(DEPTH);
  localparam logic [4:0] DEPTH_C = 5'(DEPTH);

  state_t          state_q, state_d;
  logic [3:0]      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [4:0]      count_q, count_d;
  logic            full_q, full_d;
  logic [3:0]      cmd_q, cmd_d;
  logic            cmd_valid_q, cmd_valid_d;
  logic            finished_q, finished_d;
  logic            err_q, err_d;
  logic            push_ok, pop;

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    cmd_valid_d = 1'b0;
    finished_d  = finished_q;
    pop         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (count_q != 5'd0 && !busy) begin
          pop         = 1'b1;
          cmd_d       = mem_q[rd_ptr_q];
          cmd_valid_d = 1'b1;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE:    state_d = S_WAIT_ACK;
      S_WAIT_ACK: if (busy) state_d = S_WAIT_REL;
      S_WAIT_REL: begin
        if (!busy) begin
          if (cmd_q == 4'h0 && done) begin
            state_d    = S_FINISH;
            finished_d = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_FINISH:   finished_d = 1'b1;
      default:    state_d = S_IDLE;
    endcase
  end

  // full_q is checked before any same-edge pop, so a push into a full FIFO is always dropped
  always_comb begin
    push_ok  = push && !full_q && (push_cmd <= 4'hB) && !finished_q;
    err_d    = err_q | (push && !finished_q && ((push_cmd > 4'hB) || full_q));
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + 5'(push_ok) - 5'(pop);
    full_d   = (count_d == DEPTH_C);
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_cmd;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= 5'd0;
      full_q      <= 1'b0;
      cmd_q       <= 4'h0;
      cmd_valid_q <= 1'b0;
      finished_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      cmd_q       <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
      finished_q  <= finished_d;
      err_q       <= err_d;
    end
  end

  assign full      = full_q;
  assign count     = count_q;
  assign cmd       = cmd_q;
  assign cmd_valid = cmd_valid_q;
  assign finished  = finished_q;
  assign err       = err_q;

endmodule

// File: tb/tb_lcd_cmd_seq.sv
// Bench for lcd_cmd_seq: table vectors, directed corner sequences and a randomized run,
// all checked against a queue-based model of the command handshake.
module tb_lcd_cmd_seq;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       push = 1'b0;
  logic [3:0] push_cmd = 4'h0;
  logic       busy = 1'b0;
  logic       done = 1'b0;
  logic       full, cmd_valid, finished, err;
  logic [4:0] count;
  logic [3:0] cmd;

  int n_vec  = 0;
  int n_miss = 0;

  lcd_cmd_seq #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .push(push), .push_cmd(push_cmd),
    .full(full), .count(count), .busy(busy), .done(done),
    .cmd(cmd), .cmd_valid(cmd_valid), .finished(finished), .err(err)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of pending codes plus the progress of the one outstanding command
  logic [3:0] mq [$];
  bit         m_out, m_ack, m_stb, m_fin, m_err;
  logic [3:0] m_cmd;

  task automatic model_reset();
    mq.delete();
    m_out = 0; m_ack = 0; m_stb = 0; m_fin = 0; m_err = 0;
    m_cmd = 4'h0;
  endtask

  task automatic model_edge(input bit p, input logic [3:0] c, input bit b, input bit d);
    bit do_pop, accept;
    do_pop = !m_fin && !m_out && (mq.size() > 0) && !b;
    accept = p && !m_fin && (c <= 4'hB) && (mq.size() < DEPTH);
    if (p && !m_fin && ((c > 4'hB) || (mq.size() == DEPTH))) m_err = 1;
    if (m_stb) m_stb = 0;
    else if (m_out && !m_ack) begin
      if (b) m_ack = 1;
    end else if (m_out && m_ack && !b) begin
      m_out = 0; m_ack = 0;
      if (m_cmd == 4'h0 && d) m_fin = 1;
    end
    if (do_pop) begin
      m_cmd = mq.pop_front();
      m_out = 1; m_stb = 1;
    end
    if (accept) mq.push_back(c);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("cmd_valid", 32'(cmd_valid), 32'(m_stb));
    chk("cmd",       32'(cmd),       32'(m_cmd));
    chk("count",     32'(count),     32'(mq.size()));
    chk("full",      32'(full),      32'(mq.size() == DEPTH));
    chk("finished",  32'(finished),  32'(m_fin));
    chk("err",       32'(err),       32'(m_err));
  endtask

  task automatic step(input bit p, input logic [3:0] c, input bit b, input bit d);
    push = p; push_cmd = c; busy = b; done = d;
    model_edge(p, c, b, d);
    @(posedge clk); #1;
    compare_all();
  endtask

  task automatic do_reset();
    push = 0; push_cmd = 4'h0; busy = 0; done = 0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    #1 compare_all();
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  // One full handshake from IDLE: strobe, ack, execute, release (done applied on release)
  task automatic hs(input bit d, output logic [3:0] issued);
    step(0, 4'h0, 0, 0);
    chk("hs_valid", 32'(cmd_valid), 32'd1);
    issued = cmd;
    step(0, 4'h0, 0, 0);
    step(0, 4'h0, 1, 0);
    step(0, 4'h0, 0, d);
  endtask

  typedef struct {
    bit         p;
    logic [3:0] c;
    bit         b;
    bit         d;
    bit         e_vld;
    logic [3:0] e_cmd;
    int         e_cnt;
    bit         e_err;
  } vec_t;

  vec_t tv [10];

  initial begin
    logic [3:0] got;
    int         pulses;
    logic [3:0] pcmd;

    tv[0] = '{1, 4'h5, 0, 0, 0, 4'h0, 1, 0};
    tv[1] = '{0, 4'h0, 0, 0, 1, 4'h5, 0, 0};
    tv[2] = '{0, 4'h0, 0, 0, 0, 4'h5, 0, 0};
    tv[3] = '{0, 4'h0, 1, 0, 0, 4'h5, 0, 0};
    tv[4] = '{0, 4'h0, 0, 0, 0, 4'h5, 0, 0};
    tv[5] = '{1, 4'hD, 0, 0, 0, 4'h5, 0, 1};
    tv[6] = '{1, 4'hC, 0, 0, 0, 4'h5, 0, 1};
    tv[7] = '{1, 4'hB, 1, 0, 0, 4'h5, 1, 1};
    tv[8] = '{0, 4'h0, 1, 0, 0, 4'h5, 1, 1};
    tv[9] = '{0, 4'h0, 0, 0, 1, 4'hB, 0, 1};

    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(tv[i].p, tv[i].c, tv[i].b, tv[i].d);
      chk($sformatf("tv%0d_valid", i), 32'(cmd_valid), 32'(tv[i].e_vld));
      chk($sformatf("tv%0d_cmd", i),   32'(cmd),       32'(tv[i].e_cmd));
      chk($sformatf("tv%0d_count", i), 32'(count),     32'(tv[i].e_cnt));
      chk($sformatf("tv%0d_err", i),   32'(err),       32'(tv[i].e_err));
    end

    // start-up gating: busy high for 64 cycles with a push at cycle 5
    do_reset();
    pulses = 0;
    for (int i = 0; i < 64; i++) begin
      step(i == 5, 4'h1, 1, 0);
      if (cmd_valid) pulses++;
    end
    chk("startup_gated", 32'(pulses), 32'd0);
    pcmd = 4'h0;
    for (int i = 0; i < 6; i++) begin
      step(0, 4'h0, (i == 2), 0);
      if (cmd_valid) begin pulses++; pcmd = cmd; end
    end
    chk("startup_pulses", 32'(pulses), 32'd1);
    chk("startup_cmd", 32'(pcmd), 32'h1);

    // overflow: nine pushes while busy, ninth discarded
    do_reset();
    for (int i = 1; i <= 9; i++) step(1, 4'(i), 1, 0);
    chk("ovf_count", 32'(count), 32'd8);
    chk("ovf_full", 32'(full), 32'd1);
    chk("ovf_err", 32'(err), 32'd1);
    for (int i = 1; i <= 8; i++) begin
      hs(0, got);
      chk($sformatf("ovf_order%0d", i), 32'(got), 32'(i));
    end
    for (int i = 0; i < 4; i++) step(0, 4'h0, 0, 0);
    chk("ovf_drained", 32'(count), 32'd0);

    // write-out: 3, 0 (done on release), 2 never issued
    do_reset();
    step(1, 4'h3, 1, 0);
    step(1, 4'h0, 1, 0);
    step(1, 4'h2, 1, 0);
    hs(0, got);
    chk("fin_first", 32'(got), 32'h3);
    hs(1, got);
    chk("fin_second", 32'(got), 32'h0);
    chk("fin_flag", 32'(finished), 32'd1);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step(i == 3, 4'hD, 0, 0);
      if (cmd_valid) pulses++;
    end
    chk("fin_no_issue", 32'(pulses), 32'd0);
    chk("fin_left", 32'(count), 32'd1);
    chk("fin_no_err", 32'(err), 32'd0);

    // reset while in WAIT_REL with three entries queued
    do_reset();
    for (int i = 1; i <= 4; i++) step(1, 4'(i), 1, 0);
    step(0, 4'h0, 0, 0);
    step(0, 4'h0, 0, 0);
    step(0, 4'h0, 1, 0);
    step(0, 4'h0, 1, 0);
    chk("mid_queued", 32'(count), 32'd3);
    do_reset();
    chk("mid_count", 32'(count), 32'd0);
    chk("mid_fin", 32'(finished), 32'd0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step(0, 4'h0, 0, 0);
      if (cmd_valid) pulses++;
    end
    chk("mid_no_issue", 32'(pulses), 32'd0);

    // randomized run against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0 || (m_fin && $urandom_range(0, 19) == 0)) begin
        do_reset();
      end else begin
        bit         rp, rb, rd;
        logic [3:0] rc;
        rp = ($urandom_range(0, 99) < 40);
        rc = ($urandom_range(0, 99) < 8) ? 4'($urandom_range(12, 15)) : 4'($urandom_range(0, 11));
        rb = ($urandom_range(0, 99) < 30) ? ~busy : busy;
        rd = ($urandom_range(0, 99) < 30);
        step(rp, rc, rb, rd);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
